serial_deserializer: RTL and testbench

Serial-in, parallel-out receiver, the counterpart to the team's parallel shifter. It collects a bit stream one bit per accepted beat and assembles WIDTH-bit words, either MSB-first or LSB-first. Each completed word is presented on a valid/ready output port with one word of buffering. It sits at the receive end of the serial link, feeding word-wide datapath logic.

---
 rtl/serial_deserializer_pkg.sv | 14 +
 rtl/serial_deserializer_if.sv | 29 ++
 rtl/serial_deserializer_out_buf.sv | 39 +++
 rtl/serial_deserializer.sv | 102 ++++++++++
 tb/tb_serial_deserializer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_deserializer_pkg.sv
// Shared definitions for the serial link receive/transmit pair.
//   deser_state_t : receive FSM encoding (COLLECT accepts bits, STALL holds a finished word)
//   ORDER_MSB/LSB : bit-order flag values (first bit on the wire is MSB / LSB)
package serial_deserializer_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } deser_state_t;

    localparam logic ORDER_MSB = 1'b1;
    localparam logic ORDER_LSB = 1'b0;

endpackage

// File: rtl/serial_deserializer_if.sv
// Handshake bundle for serial_deserializer.
//   serial side : s_valid, s_ready, s_bit, msb_first, sync
//   word side   : m_valid, m_ready, m_data
//   status      : bit_cnt (bits collected in the current partial word)
// master = the environment driving bits and consuming words; slave = the deserializer.
interface serial_deserializer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) ();
    logic             s_valid;
    logic             s_ready;
    logic             s_bit;
    logic             msb_first;
    logic             sync;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output s_valid, s_bit, msb_first, sync, m_ready,
        input  s_ready, m_valid, m_data, bit_cnt
    );

    modport slave (
        input  s_valid, s_bit, msb_first, sync, m_ready,
        output s_ready, m_valid, m_data, bit_cnt
    );
endinterface

// File: rtl/serial_deserializer_out_buf.sv
// One-word output register with valid/ready handshake.
//   clk, rst : clock, synchronous active-high reset
//   i_load   : capture i_data this cycle (caller guarantees the slot is free or draining)
//   i_data   : word to capture
//   i_ready  : downstream accepts the presented word
//   o_valid  : word presented
//   o_data   : presented word, held stable until it is replaced
module deser_out_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            // Drain: data is left in place, only valid drops.
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-in, parallel-out receiver: assembles WIDTH-bit words MSB- or LSB-first
// and presents them through a one-word valid/ready output buffer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : serial_deserializer_if.slave (serial input, word output, bit_cnt status)
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_deserializer_if.slave  bus
);

    deser_state_t     r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_order;

    logic             w_collect;
    logic             w_accept;
    logic             w_order;
    logic [WIDTH-1:0] w_shift;
    logic             w_last;
    logic             w_can_load;
    logic             w_load;
    logic [WIDTH-1:0] w_load_data;
    logic             w_m_valid;
    logic [WIDTH-1:0] w_m_data;

    assign w_collect = (r_state == COLLECT);
    // sync discards a bit offered in the same cycle, so it blocks the accept.
    assign w_accept  = bus.s_valid && w_collect && !bus.sync;
    // The first bit of a word uses the live msb_first; later bits use the latched flag.
    assign w_order   = (r_cnt == '0) ? bus.msb_first : r_order;
    assign w_shift   = (w_order == ORDER_MSB) ? {r_acc[WIDTH-2:0], bus.s_bit}
                                              : {bus.s_bit, r_acc[WIDTH-1:1]};
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_can_load = !w_m_valid || bus.m_ready;

    // Load the output buffer either with a word completing this cycle or,
    // when stalled, with the word parked in the accumulator.
    assign w_load      = (w_accept && w_last && w_can_load) || (!w_collect && bus.m_ready);
    assign w_load_data = w_collect ? w_shift : r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_order <= ORDER_MSB;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (bus.sync) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                    end else if (w_accept) begin
                        if (r_cnt == '0) begin
                            r_order <= bus.msb_first;
                        end
                        r_acc <= w_shift;
                        if (w_last) begin
                            r_cnt <= '0;
                            if (!w_can_load) begin
                                r_state <= STALL;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                STALL: begin
                    if (bus.m_ready) begin
                        r_acc   <= '0;
                        r_state <= COLLECT;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    deser_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_ready (bus.m_ready),
        .o_valid (w_m_valid),
        .o_data  (w_m_data)
    );

    assign bus.s_ready = w_collect;
    assign bus.m_valid = w_m_valid;
    assign bus.m_data  = w_m_data;
    assign bus.bit_cnt = r_cnt;

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer (WIDTH=8): stimulus pushes expected
// words, a negedge monitor pops and compares on every output handshake.
module tb_serial_deserializer;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_deserializer_if #(.WIDTH(WIDTH)) bus ();

    serial_deserializer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               hs_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake seen at negedge completes at the next posedge.
    always @(negedge clk) begin
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            hs_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_word", {24'h0, bus.m_data}, 32'hDEAD);
            end else begin
                check("m_data", {24'h0, bus.m_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_bit(input logic b);
        bus.s_valid = 1'b1;
        bus.s_bit   = b;
        step();
        bus.s_valid = 1'b0;
    endtask

    // Sends w in the wire order selected by msb.
    task automatic send_word(input logic [WIDTH-1:0] w, input logic msb);
        bus.msb_first = msb;
        for (int i = 0; i < WIDTH; i++) begin
            send_bit(msb ? w[WIDTH-1-i] : w[i]);
        end
    endtask

    logic [7:0] pat;

    initial begin
        rst           = 1'b1;
        bus.s_valid   = 1'b0;
        bus.s_bit     = 1'b0;
        bus.msb_first = 1'b1;
        bus.sync      = 1'b0;
        bus.m_ready   = 1'b1;
        idle(2);
        rst = 1'b0;

        // Reset state
        check("rst_m_valid", {31'h0, bus.m_valid}, 32'h0);
        check("rst_m_data",  {24'h0, bus.m_data},  32'h0);
        check("rst_bit_cnt", {29'h0, bus.bit_cnt}, 32'h0);
        check("rst_s_ready", {31'h0, bus.s_ready}, 32'h1);

        // MSB-first 0,0,0,1,0,0,1,0 -> 0x12
        exp_q.push_back(8'h12);
        send_word(8'h12, 1'b1);
        check("msb_valid_rise", {31'h0, bus.m_valid}, 32'h1);
        check("msb_cnt_wrap",   {29'h0, bus.bit_cnt}, 32'h0);
        step();
        check("msb_valid_pulse", {31'h0, bus.m_valid}, 32'h0);

        // LSB-first, same wire bits -> 0x48
        pat = 8'b0001_0010;  // wire order, index 7 sent first
        exp_q.push_back(8'h48);
        bus.msb_first = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(pat[7-i]);
        idle(1);

        // LSB-first with msb_first toggled after bit 3 -> still 0x48
        exp_q.push_back(8'h48);
        bus.msb_first = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) bus.msb_first = 1'b1;
            send_bit(pat[7-i]);
        end
        idle(1);

        // Backpressure: 0x12 buffered, 0x34 stalls in the accumulator
        bus.m_ready = 1'b0;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        send_word(8'h12, 1'b1);
        send_word(8'h34, 1'b1);
        check("stall_s_ready", {31'h0, bus.s_ready}, 32'h0);
        check("stall_m_data",  {24'h0, bus.m_data},  32'h12);
        bus.s_valid = 1'b1;
        bus.s_bit   = 1'b1;
        idle(3);
        bus.s_valid = 1'b0;
        check("stall_no_accept", {29'h0, bus.bit_cnt}, 32'h0);
        check("stall_hold_data", {24'h0, bus.m_data},  32'h12);
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        check("unstall_m_data",  {24'h0, bus.m_data},  32'h34);
        check("unstall_m_valid", {31'h0, bus.m_valid}, 32'h1);
        check("unstall_s_ready", {31'h0, bus.s_ready}, 32'h1);
        bus.m_ready = 1'b1;
        idle(2);

        // Back-to-back 0xA5, 0x5A with no bubbles
        hs_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        bus.msb_first = 1'b1;
        for (int w = 0; w < 2; w++) begin
            pat = (w == 0) ? 8'hA5 : 8'h5A;
            for (int i = 0; i < 8; i++) begin
                check("b2b_s_ready", {31'h0, bus.s_ready}, 32'h1);
                send_bit(pat[7-i]);
            end
        end
        idle(2);
        check("b2b_count", hs_q.size(), 32'd2);
        if (hs_q.size() == 2) check("b2b_gap", hs_q[1] - hs_q[0], 32'd8);

        // sync drops a partial word and the bit offered with it
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        bus.sync = 1'b1;
        send_bit(1'b1);
        bus.sync = 1'b0;
        check("sync_cnt_clear", {29'h0, bus.bit_cnt}, 32'h0);
        exp_q.push_back(8'hC3);
        send_word(8'hC3, 1'b1);
        idle(2);

        // sync during STALL keeps the held word
        bus.m_ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_word(8'h11, 1'b1);
        send_word(8'h22, 1'b1);
        bus.sync = 1'b1;
        idle(2);
        bus.sync = 1'b0;
        check("sync_stall_s_ready", {31'h0, bus.s_ready}, 32'h0);
        bus.m_ready = 1'b1;
        idle(3);

        // Reset mid-word with a word pending on the output
        bus.m_ready = 1'b0;
        send_word(8'h77, 1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("pre_rst_cnt", {29'h0, bus.bit_cnt}, 32'h5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_m_valid", {31'h0, bus.m_valid}, 32'h0);
        check("mid_rst_m_data",  {24'h0, bus.m_data},  32'h0);
        check("mid_rst_bit_cnt", {29'h0, bus.bit_cnt}, 32'h0);
        check("mid_rst_s_ready", {31'h0, bus.s_ready}, 32'h1);
        bus.m_ready = 1'b1;
        exp_q.push_back(8'h3C);
        send_word(8'h3C, 1'b1);
        idle(3);

        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
